// File: rtl/ioctl_upload_reader_pkg.sv
// Shared types and constants for the ioctl upload (read-back) responder.
package ioctl_upload_reader_pkg;

    // Request lifecycle: wait for a strobe, win the RAM port, ride out the
    // RAM pipeline, or answer an out-of-range index without touching RAM.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StLat   = 2'd2,
        StFillv = 2'd3
    } state_e;

    // Byte returned for indices past the end of the exposed window.
    localparam logic [7:0] FillDefault = 8'hFF;

    // The served-reads counter sticks at all-ones instead of wrapping.
    localparam logic [16:0] BytesReadMax = 17'h1FFFF;

    function automatic logic [16:0] sat_inc(input logic [16:0] v);
        return (v == BytesReadMax) ? v : v + 17'd1;
    endfunction

endpackage

// File: rtl/ioctl_upload_reader.sv
// Core-side responder for hps_io upload reads: one RAM byte per ioctl_rd
// strobe, fetched through an arbitrated read port, with ioctl_wait held
// until the byte is on ioctl_din.
module ioctl_upload_reader
    import ioctl_upload_reader_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int unsigned       UPLOAD_BYTES = 65536,
    parameter int unsigned       RAM_LATENCY  = 1,
    parameter logic [7:0]        FILL         = FillDefault
) (
    input  logic              clk_sys_i,
    input  logic              reset_i,
    input  logic              ioctl_upload_i,
    input  logic              ioctl_rd_i,
    input  logic [24:0]       ioctl_addr_i,
    output logic [7:0]        ioctl_din_o,
    output logic              ioctl_wait_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_q_i,
    output logic [16:0]       bytes_read_o,
    output logic              done_o,
    output logic              overrun_o
);

    // One extra bit so a window covering the full 25-bit index space still compares correctly.
    localparam logic [25:0] UploadLimit = 26'(UPLOAD_BYTES);
    localparam logic [1:0]  LatInit     = 2'(RAM_LATENCY - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [1:0]         lat_q, lat_d;
    logic [7:0]         din_q, din_d;
    logic [16:0]        bytes_q, bytes_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic               upload_q, upload_d;
    logic               in_range;

    assign in_range = ({1'b0, ioctl_addr_i} < UploadLimit);

    // Next-state logic: FSM transitions, data capture, session bookkeeping.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        lat_d      = lat_q;
        din_d      = din_q;
        bytes_d    = bytes_q;
        overrun_d  = overrun_q;
        upload_d   = ioctl_upload_i;
        done_d     = upload_q & ~ioctl_upload_i;

        if (!ioctl_upload_i) begin
            // Session ended: abandon any in-flight read without side effects.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ioctl_rd_i) begin
                        mem_addr_d = BASE_ADDR + ioctl_addr_i[ADDR_W-1:0];
                        state_d    = in_range ? StReq : StFillv;
                    end
                end
                StReq: begin
                    if (mem_gnt_i) begin
                        lat_d   = LatInit;
                        state_d = StLat;
                    end
                end
                StLat: begin
                    if (lat_q == 2'd0) begin
                        din_d   = mem_q_i;
                        bytes_d = sat_inc(bytes_q);
                        state_d = StIdle;
                    end else begin
                        lat_d = lat_q - 2'd1;
                    end
                end
                StFillv: begin
                    din_d   = FILL;
                    bytes_d = sat_inc(bytes_q);
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase

            // A strobe while busy is dropped; flag it so the host can tell.
            if (ioctl_rd_i && (state_q != StIdle)) begin
                overrun_d = 1'b1;
            end

            // Session start wins over everything else for the counters.
            if (!upload_q) begin
                bytes_d   = '0;
                overrun_d = 1'b0;
            end
        end
    end

    // State and registered outputs; reset returns everything to zero at once.
    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            mem_addr_q <= '0;
            lat_q      <= '0;
            din_q      <= '0;
            bytes_q    <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            upload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            lat_q      <= lat_d;
            din_q      <= din_d;
            bytes_q    <= bytes_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            upload_q   <= upload_d;
        end
    end

    // Wait covers the strobe cycle combinationally so hps_io never sees a gap.
    assign ioctl_wait_o = (state_q != StIdle) | (ioctl_rd_i & ioctl_upload_i);
    // Request is gated by the session level so an abort releases the port immediately.
    assign mem_req_o    = (state_q == StReq) & ioctl_upload_i;
    assign mem_addr_o   = mem_addr_q;
    assign ioctl_din_o  = din_q;
    assign bytes_read_o = bytes_q;
    assign done_o       = done_q;
    assign overrun_o    = overrun_q;

endmodule
